// File: rtl/reset_sequencer.sv
// reset_sequencer: merges lock/button/software/watchdog faults and releases
// ordered stage resets. Optional watchdog: define RESET_SEQUENCER_WATCHDOG_EN.
module reset_sequencer #(
    parameter int CLK_FREQ           = 10_125_000,
    parameter int NUM_LOCKS          = 1,
    parameter int NUM_STAGES         = 2,
    parameter int STAGE_DELAY_CYCLES = 1024,
    parameter int DEBOUNCE_CYCLES    = CLK_FREQ / 100,
    parameter int WDT_CYCLES         = CLK_FREQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_n,
    input  logic [NUM_LOCKS-1:0]  lock,
    input  logic                  sw_rst_req,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_released,
    output logic [3:0]            cause
);

    localparam int CW = (STAGE_DELAY_CYCLES > 1) ? $clog2(STAGE_DELAY_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IW = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {ASSERT, WAIT, RELEASE, RUN} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] rel, rel_nx;
    logic [NUM_STAGES-1:0] rst_nx;

    logic [NUM_LOCKS-1:0] lock_m, lock_s;
    logic btn_m, btn_s, btn_acc;
    logic [DW-1:0] deb_cnt;
    logic por;
    logic wdt_expire;
    logic [3:0] fault_bits;
    logic fault;

    // two-flop synchronizers; reset to pressed / unlocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= '0;
            lock_s <= '0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
            btn_m  <= btn_n;
            btn_s  <= btn_m;
        end
    end

    // accept a new button level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_acc <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_acc) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_acc <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    logic [WW-1:0] wdt_cnt;

    // watchdog runs only in RUN and reloads on kick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (state != RUN || wdt_kick) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_expire = (state == RUN) && (wdt_cnt == WW'(WDT_CYCLES - 1));
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_expire = 1'b0;
`endif

    assign fault_bits = {wdt_expire, sw_rst_req, ~btn_acc, ~&lock_s};
    assign fault      = |fault_bits;

    // sequencer next state, stage count and registered output values
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rel_nx   = rel;
        rst_nx   = '1;
        unique case (state)
            ASSERT: begin
                cnt_nx = '0;
                rel_nx = '0;
                if (!fault) state_nx = WAIT;
            end
            WAIT: begin
                if (fault) begin
                    state_nx = ASSERT;
                    cnt_nx   = '0;
                end else if (cnt == CW'(STAGE_DELAY_CYCLES - 1)) begin
                    state_nx = (NUM_STAGES == 1) ? RUN : RELEASE;
                    rel_nx   = IW'(1);
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (fault) begin
                    state_nx = ASSERT;
                    cnt_nx   = '0;
                    rel_nx   = '0;
                end else if (cnt == CW'(STAGE_DELAY_CYCLES - 1)) begin
                    rel_nx = rel + 1'b1;
                    cnt_nx = '0;
                    if (rel + 1'b1 == IW'(NUM_STAGES)) state_nx = RUN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (fault) begin
                    state_nx = ASSERT;
                    rel_nx   = '0;
                end
            end
            default: begin
                state_nx = ASSERT;
                cnt_nx   = '0;
                rel_nx   = '0;
            end
        endcase
        for (int i = 0; i < NUM_STAGES; i++) begin
            rst_nx[i] = (rel_nx <= IW'(i));
        end
    end

    // sequencer state and glitch-free registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ASSERT;
            cnt          <= '0;
            rel          <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            rel          <= rel_nx;
            rst_out      <= rst_nx;
            all_released <= (state_nx == RUN);
        end
    end

    // cause: overwrite on ASSERT entry, accumulate while held; the power-on
    // hold ignores the synchronizer/debounce start-up faults so cause stays 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause <= '0;
            por   <= 1'b1;
        end else if (state != ASSERT) begin
            if (fault) cause <= fault_bits;
        end else begin
            cause <= cause | (fault_bits & (por ? 4'b1100 : 4'b1111));
            if (!fault) por <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized scoreboard bench against a
// timing-rule reference model of the reset sequencer.
module tb_reset_sequencer;

    localparam int NL  = 2;
    localparam int NS  = 3;
    localparam int SD  = 4;
    localparam int DEB = 8;
    localparam int WDT = 16;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [NS-1:0] ro;
        logic          ar;
        logic [3:0]    c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_n = 1'b1;
    logic [NL-1:0] lock = '1;
    logic          sw_rst_req = 1'b0;
    logic          wdt_kick = 1'b0;
    logic [NS-1:0] rst_out;
    logic          all_released;
    logic [3:0]    cause;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    reset_sequencer #(
        .NUM_LOCKS(NL),
        .NUM_STAGES(NS),
        .STAGE_DELAY_CYCLES(SD),
        .DEBOUNCE_CYCLES(DEB),
        .WDT_CYCLES(WDT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n(btn_n),
        .lock(lock),
        .sw_rst_req(sw_rst_req),
        .wdt_kick(wdt_kick),
        .rst_out(rst_out),
        .all_released(all_released),
        .cause(cause)
    );

    always #5 clk = ~clk;

    // reference model: inputs seen two edges late, button accepted after
    // DEB differing samples, stages fall every SD edges after the first
    // fault-free edge while asserted
    logic [NL-1:0] lq[$];
    logic          bq[$];
    logic [NL-1:0] s_lock;
    logic          s_btn;
    logic [3:0]    bits;
    bit            running;
    bit            m_acc, m_assert, m_por;
    int            m_run, m_t, m_wd, m_rel;
    logic [3:0]    m_cause;
    exp_t          pe;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            lq = {};
            bq = {};
            lq.push_back('0);
            lq.push_back('0);
            bq.push_back(1'b0);
            bq.push_back(1'b0);
            m_acc = 0;
            m_assert = 1;
            m_por = 1;
            m_run = 0;
            m_t = 0;
            m_wd = 0;
            m_rel = 0;
            m_cause = '0;
        end else begin
            s_lock  = lq[0];
            s_btn   = bq[0];
            running = !m_assert && (m_rel == NS);
            bits[0] = (s_lock != '1);
            bits[1] = !m_acc;
            bits[2] = sw_rst_req;
            bits[3] = WDT_ON && running && (m_wd == WDT - 1);
            if (s_btn != m_acc) begin
                m_run++;
                if (m_run == DEB) begin
                    m_acc = s_btn;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            void'(lq.pop_front());
            lq.push_back(lock);
            void'(bq.pop_front());
            bq.push_back(btn_n);
            if (!running || wdt_kick) m_wd = 0;
            else m_wd++;
            if (m_assert) begin
                if (bits != 0) begin
                    m_cause |= bits & (m_por ? 4'b1100 : 4'b1111);
                end else begin
                    m_assert = 0;
                    m_t = 0;
                    m_por = 0;
                end
            end else if (bits != 0) begin
                m_assert = 1;
                m_cause = bits;
            end else if (m_t < 1000000) begin
                m_t++;
            end
            m_rel = m_assert ? 0 : ((m_t / SD > NS) ? NS : m_t / SD);
        end
        pe.ro = '1;
        for (int i = 0; i < NS; i++) pe.ro[i] = (i >= m_rel);
        pe.ar = !m_assert && (m_rel == NS);
        pe.c  = m_cause;
        sb.push_back(pe);
    end

    // monitor: one expected entry per edge, compared mid-cycle
    exp_t me;
    always @(negedge clk) begin
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: queue size 0, required at least 1");
        end else begin
            me = sb.pop_front();
            if ({rst_out, all_released, cause} !== me) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL seq_cyc%0d: got rst_out=%b all_rel=%b cause=%b, want %b %b %b",
                             cyc, rst_out, all_released, cause, me.ro, me.ar, me.c);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        // power-on
        step(3);
        rst = 1'b0;
        step(40);

        // single-cycle lock loss from RUN
        lock[1] = 1'b0;
        step();
        lock[1] = 1'b1;
        step(40);

        // short bounces, then a real press and release
        for (int k = 0; k < 3; k++) begin
            btn_n = 1'b0;
            step(5);
            btn_n = 1'b1;
            step(5);
        end
        btn_n = 1'b0;
        step(12);
        btn_n = 1'b1;
        step(50);

        // software reset from RUN
        sw_pulse();
        step(7);

        // software reset while rst_out is 100
        for (int i = 0; i < 200; i++) begin
            if (!m_assert && m_rel == 2) break;
            step();
        end
        sw_pulse();
        step(30);

        // software request logged during an ASSERT hold
        lock[0] = 1'b0;
        step();
        lock[0] = 1'b1;
        step(2);
        sw_pulse();
        step(30);

        // watchdog kicked, then left alone
        for (int k = 0; k < 6; k++) begin
            wdt_kick = 1'b1;
            step();
            wdt_kick = 1'b0;
            step(9);
        end
        step(40);

        // asynchronous reset assertion mid-run
        rst = 1'b1;
        #1;
        n_chk++;
        if (rst_out !== '1 || all_released !== 1'b0 || cause !== 4'b0) begin
            n_fail++;
            $display("FAIL async_rst: got rst_out=%b all_rel=%b cause=%b, want 111 0 0000",
                     rst_out, all_released, cause);
        end
        step(3);
        rst = 1'b0;
        step(40);

        // random mix of all fault sources
        for (int i = 0; i < 400; i++) begin
            lock = '1;
            sw_rst_req = 1'b0;
            wdt_kick = 1'b0;
            if ($urandom_range(63) == 0) lock[$urandom_range(NL - 1)] = 1'b0;
            if ($urandom_range(99) == 0) sw_rst_req = 1'b1;
            if ($urandom_range(3) == 0) wdt_kick = 1'b1;
            if ($urandom_range(19) == 0) btn_n = ~btn_n;
            step();
        end
        lock = '1;
        sw_rst_req = 1'b0;
        wdt_kick = 1'b0;
        btn_n = 1'b1;
        step(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
